// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command responder.
//   - state_t   : parser / reply FSM encoding
//   - ASC_*     : ASCII byte constants used by the command grammar and replies
//   - REPLY_LEN : every reply is exactly four bytes
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RA_HI,
        ST_RA_LO,
        ST_WA_HI,
        ST_WA_LO,
        ST_WD_HI,
        ST_WD_LO,
        ST_WAIT_CR,
        ST_DISCARD,
        ST_EXEC,
        ST_SEND
    } state_t;

    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_R_UC = 8'h52;
    localparam logic [7:0] ASC_R_LC = 8'h72;
    localparam logic [7:0] ASC_W_UC = 8'h57;
    localparam logic [7:0] ASC_W_LC = 8'h77;
    localparam logic [7:0] ASC_O    = 8'h4F;
    localparam logic [7:0] ASC_K    = 8'h4B;
    localparam logic [7:0] ASC_E    = 8'h45;

    localparam int REPLY_LEN = 4;

endpackage

// File: rtl/hex_ascii_codec.sv
// hex_ascii_codec: combinational ASCII <-> hex nibble conversion.
//   ascii_in  [7:0] : byte to decode ('0'-'9', 'A'-'F', 'a'-'f')
//   nib_out   [3:0] : decoded nibble (0 when not a hex digit)
//   nib_valid       : ascii_in is a hex digit
//   nib_in    [3:0] : nibble to encode
//   ascii_out [7:0] : uppercase ASCII hex digit for nib_in
module hex_ascii_codec (
    input  logic [7:0] ascii_in,
    output logic [3:0] nib_out,
    output logic       nib_valid,
    input  logic [3:0] nib_in,
    output logic [7:0] ascii_out
);

    logic [7:0] diff;

    always_comb begin
        nib_out   = 4'h0;
        nib_valid = 1'b0;
        diff      = 8'h00;
        if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
            diff      = ascii_in - 8'h30;
            nib_valid = 1'b1;
        end else if (ascii_in >= 8'h41 && ascii_in <= 8'h46) begin
            diff      = ascii_in - 8'h37;
            nib_valid = 1'b1;
        end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
            diff      = ascii_in - 8'h57;
            nib_valid = 1'b1;
        end
        nib_out = diff[3:0];
    end

    assign ascii_out = (nib_in < 4'd10) ? {4'h3, nib_in} : (8'h37 + {4'h0, nib_in});

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses ASCII hex register commands from the UART rx FIFO,
// drives a small register bus and pushes ASCII replies into the tx FIFO.
//   Read : 'R'|'r' hh CR      -> hh CR LF  (reg_rdata in uppercase hex)
//   Write: 'W'|'w' hh hh CR   -> "OK" CR LF
//   Bad  : anything else      -> "ER" CR LF once a CR arrives
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   rx_empty, r_data       : rx FIFO status / head byte
//   rd_uart                : rx FIFO pop strobe (combinational)
//   tx_full                : tx FIFO full flag
//   w_data, wr_uart        : tx FIFO data / push strobe (combinational)
//   reg_addr, reg_wdata    : register bus address / write data (held after use)
//   reg_we, reg_re         : one-cycle register write / read strobes
//   reg_rdata              : register read data, combinational from reg_addr
//   busy                   : a command or its reply is in progress
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int                 TO_BITS = 24,
    parameter logic [TO_BITS-1:0] TO_MAX  = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    state_t                         state;
    logic                           err;
    logic                           is_wr;
    logic [7:0]                     addr_sh;
    logic [7:0]                     data_sh;
    logic [REPLY_LEN-1:0][7:0]      rbuf;
    logic [1:0]                     idx;
    logic [TO_BITS-1:0]             to_cnt;

    logic       rx_st;
    logic       tmo;
    logic [3:0] rx_nib;
    logic       rx_hex;
    logic [7:0] rd_hi_asc;
    logic [7:0] rd_lo_asc;
    logic [3:0] unused_enc_nib;
    logic       unused_enc_vld;

    // The decode instance's (otherwise idle) encode path converts the low
    // read-data nibble; the encode instance converts the high nibble.
    hex_ascii_codec u_dec (
        .ascii_in  (r_data),
        .nib_out   (rx_nib),
        .nib_valid (rx_hex),
        .nib_in    (reg_rdata[3:0]),
        .ascii_out (rd_lo_asc)
    );

    hex_ascii_codec u_enc (
        .ascii_in  (8'h00),
        .nib_out   (unused_enc_nib),
        .nib_valid (unused_enc_vld),
        .nib_in    (reg_rdata[7:4]),
        .ascii_out (rd_hi_asc)
    );

    assign rx_st   = (state != ST_EXEC) && (state != ST_SEND);
    assign rd_uart = ~reset & rx_st & ~rx_empty;
    assign wr_uart = ~reset & (state == ST_SEND) & ~tx_full;
    assign w_data  = rbuf[idx];
    assign busy    = (state != ST_IDLE);
    assign tmo     = (TO_MAX != '0) && (to_cnt == TO_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            err       <= 1'b0;
            is_wr     <= 1'b0;
            addr_sh   <= 8'h00;
            data_sh   <= 8'h00;
            rbuf      <= '0;
            idx       <= 2'd0;
            to_cnt    <= '0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (state == ST_EXEC) begin
                // Buffer is sent index 0 first, so the first reply char sits in the low byte.
                if (err)
                    rbuf <= {ASC_LF, ASC_CR, ASC_R_UC, ASC_E};
                else if (is_wr)
                    rbuf <= {ASC_LF, ASC_CR, ASC_K, ASC_O};
                else
                    rbuf <= {ASC_LF, ASC_CR, rd_lo_asc, rd_hi_asc};
                idx   <= 2'd0;
                err   <= 1'b0;
                state <= ST_SEND;
            end else if (state == ST_SEND) begin
                if (wr_uart) begin
                    idx <= idx + 2'd1;
                    if (idx == 2'(REPLY_LEN - 1))
                        state <= ST_IDLE;
                end
            end else if (rd_uart) begin
                to_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (r_data == ASC_R_UC || r_data == ASC_R_LC) begin
                            is_wr <= 1'b0;
                            state <= ST_RA_HI;
                        end else if (r_data == ASC_W_UC || r_data == ASC_W_LC) begin
                            is_wr <= 1'b1;
                            state <= ST_WA_HI;
                        end else if (r_data != ASC_CR && r_data != ASC_LF) begin
                            err   <= 1'b1;
                            state <= ST_DISCARD;
                        end
                    end
                    ST_RA_HI, ST_WA_HI: begin
                        addr_sh[7:4] <= rx_nib;
                        state        <= (state == ST_RA_HI) ? ST_RA_LO : ST_WA_LO;
                    end
                    ST_RA_LO: begin
                        addr_sh[3:0] <= rx_nib;
                        state        <= ST_WAIT_CR;
                    end
                    ST_WA_LO: begin
                        addr_sh[3:0] <= rx_nib;
                        state        <= ST_WD_HI;
                    end
                    ST_WD_HI: begin
                        data_sh[7:4] <= rx_nib;
                        state        <= ST_WD_LO;
                    end
                    ST_WD_LO: begin
                        data_sh[3:0] <= rx_nib;
                        state        <= ST_WAIT_CR;
                    end
                    ST_WAIT_CR: begin
                        if (r_data == ASC_CR) begin
                            // Commit the bus address/data only for a complete command.
                            reg_addr <= addr_sh;
                            if (is_wr) begin
                                reg_wdata <= data_sh;
                                reg_we    <= 1'b1;
                            end else begin
                                reg_re <= 1'b1;
                            end
                            state <= ST_EXEC;
                        end else begin
                            err   <= 1'b1;
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (r_data == ASC_CR)
                            state <= ST_EXEC;
                    end
                    default: state <= ST_IDLE;
                endcase
                // Any non-hex byte in a nibble state aborts to DISCARD; overrides the advance above.
                if (!rx_hex && (state == ST_RA_HI || state == ST_RA_LO || state == ST_WA_HI ||
                                state == ST_WA_LO || state == ST_WD_HI || state == ST_WD_LO)) begin
                    err   <= 1'b1;
                    state <= ST_DISCARD;
                end
            end else if (state != ST_IDLE) begin
                if (tmo) begin
                    to_cnt <= '0;
                    err    <= 1'b0;
                    state  <= ST_IDLE;
                end else begin
                    to_cnt <= to_cnt + TO_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: queue-based rx/tx FIFO models and a
// 256-entry register model; expected replies are hand-computed ASCII.
module tb_uart_cmd_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       tx_full = 1'b0;
    logic       rd_uart, wr_uart, reg_we, reg_re, busy;
    logic [7:0] w_data, reg_addr, reg_wdata, reg_rdata;

    logic [7:0] regs [256];
    assign reg_rdata = regs[reg_addr];

    always #5 clk = ~clk;

    uart_cmd_responder #(.TO_MAX(24'd100)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    int         txc [$];
    int         cyc = 0;
    int         last_pop = 0;
    int         re_cnt = 0, we_cnt = 0, both_cnt = 0;
    logic [7:0] re_addr = 8'h00, we_addr = 8'h00, we_data = 8'h00;
    logic       pop_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample DUT outputs mid-cycle; the pop/push take effect at the next edge.
    always @(negedge clk) begin
        pop_pend = rd_uart;
        if (rd_uart) last_pop = cyc;
        if (wr_uart) begin
            txq.push_back(w_data);
            txc.push_back(cyc);
        end
        if (reg_re) begin
            re_cnt++;
            re_addr = reg_addr;
        end
        if (reg_we) begin
            we_cnt++;
            we_addr = reg_addr;
            we_data = reg_wdata;
            regs[reg_addr] = reg_wdata;
        end
        if (reg_re && reg_we) both_cnt++;
    end

    // rx FIFO model: pop what the DUT consumed, then present the new head.
    always @(posedge clk) begin
        #1;
        if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input string s);
        foreach (s[i]) rxq.push_back(8'(s[i]));
    endtask

    task automatic cmd(input string s);
        send(s);
        rxq.push_back(8'h0D);
    endtask

    task automatic clr();
        txq.delete();
        txc.delete();
        re_cnt = 0;
        we_cnt = 0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 400 && txq.size() < n; i++) tick(1);
    endtask

    function automatic logic [31:0] tx_word(input int b);
        if (txq.size() >= b + 4) return {txq[b], txq[b+1], txq[b+2], txq[b+3]};
        return 32'hDEAD_DEAD;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h3C] = 8'hA5;
        regs[8'h00] = 8'h5A;
        regs[8'h12] = 8'hC3;

        // Reset state, with a byte waiting in the rx FIFO
        rxq.push_back(8'h0D);
        tick(3);
        chk("rst_rd_uart", rd_uart, 0);
        chk("rst_strobes", {wr_uart, reg_we, reg_re, busy}, 4'b0000);
        chk("rst_bus", {reg_addr, reg_wdata, w_data}, 24'h000000);
        reset = 1'b0;
        tick(3);
        chk("idle_cr_popped", rxq.size(), 0);
        chk("idle_cr_ignored", {busy, 8'(txq.size())}, 9'h000);

        // Basic read
        clr();
        cmd("R3C");
        tick(2);
        chk("busy_in_cmd", busy, 1);
        wait_tx(4);
        tick(3);
        chk("rd3c_reply", tx_word(0), 32'h41350D0A);
        chk("rd3c_re", {8'(re_cnt), re_addr, 8'(we_cnt)}, 24'h013C00);
        chk("rd3c_latency", (txc.size() > 0) ? txc[0] - last_pop : -1, 2);
        chk("rd3c_burst", (txc.size() > 3) ? txc[3] - txc[0] : -1, 3);
        chk("rd3c_busy_done", busy, 0);

        // Lower-case write, then read it back
        clr();
        cmd("w1f7e");
        wait_tx(4);
        tick(3);
        chk("wr1f_reply", tx_word(0), 32'h4F4B0D0A);
        chk("wr1f_we", {8'(we_cnt), we_addr, we_data, 8'(re_cnt)}, 32'h011F7E00);
        chk("wr1f_hold", {reg_addr, reg_wdata}, 16'h1F7E);
        clr();
        cmd("R1F");
        wait_tx(4);
        tick(3);
        chk("rd1f_reply", tx_word(0), 32'h37450D0A);

        // Bad hex digit, then recovery
        clr();
        cmd("RG1");
        wait_tx(4);
        tick(3);
        chk("bad_reply", tx_word(0), 32'h45520D0A);
        chk("bad_no_strobe", {8'(re_cnt), 8'(we_cnt)}, 16'h0000);
        clr();
        cmd("R00");
        wait_tx(4);
        tick(3);
        chk("rd00_reply", tx_word(0), 32'h35410D0A);
        chk("rd00_addr", {8'(re_cnt), re_addr}, 16'h0100);

        // tx back-pressure after the first reply byte, with a queued command
        clr();
        cmd("R3C");
        wait_tx(1);
        tx_full = 1'b1;
        cmd("R00");
        tick(20);
        chk("stall_no_push", txq.size(), 1);
        chk("stall_no_pop", rxq.size(), 4);
        tx_full = 1'b0;
        wait_tx(8);
        tick(3);
        chk("stall_reply1", tx_word(0), 32'h41350D0A);
        chk("stall_reply2", tx_word(4), 32'h35410D0A);
        chk("stall_count", txq.size(), 8);

        // Inter-byte timeout aborts a stale write silently
        clr();
        send("W12");
        tick(150);
        chk("tmo_idle", busy, 0);
        chk("tmo_silent", {8'(we_cnt), 8'(txq.size())}, 16'h0000);
        cmd("R12");
        wait_tx(4);
        tick(3);
        chk("tmo_rd12_reply", tx_word(0), 32'h43330D0A);
        chk("tmo_no_write", we_cnt, 0);

        // Reset during the second reply byte
        clr();
        cmd("R3C");
        wait_tx(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst_mid_out", {wr_uart, busy, reg_we, reg_re}, 4'b0000);
        chk("rst_mid_count", txq.size(), 1);
        tick(2);
        clr();
        cmd("R00");
        wait_tx(4);
        tick(3);
        chk("rst_rd00_reply", tx_word(0), 32'h35410D0A);

        chk("we_re_excl", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
